// File: rtl/chacha_core.sv
// chacha_core: iterative ChaCha block function, ROUNDS rounds at QR_PER_CYCLE quarter-rounds per clock.
module chacha_core #(
    parameter int ROUNDS       = 20,
    parameter int QR_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] block_out
);
    localparam int STEPS = ROUNDS * 4 / QR_PER_CYCLE;
    localparam logic [6:0] LAST = 7'(STEPS - 1);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("ROUNDS must be 8, 12 or 20");
    end
    if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 2 || QR_PER_CYCLE == 4)) begin : g_bad_qr
        $error("QR_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t            state;
    logic [6:0]        step;
    logic [15:0][31:0] work, saved, init, nxt;
    logic [2:0]        pos;
    logic [127:0]      r;

    function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
        logic [31:0] a, b, c, d;
        a = a_in + b_in; d = d_in ^ a; d = {d[15:0], d[31:16]};
        c = c_in + d;    b = b_in ^ c; b = {b[19:0], b[31:20]};
        a = a + b;       d = d ^ a;    d = {d[23:0], d[31:24]};
        c = c + d;       b = b ^ c;    b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // word k of quarter-round j: j<4 are columns, j>=4 diagonals shifted by k
    function automatic logic [3:0] idx(input int j, input int k);
        return 4'(4 * k + (j % 4 + (j < 4 ? 0 : k)) % 4);
    endfunction

    assign init     = {nonce, counter, key, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    assign pos      = 3'(int'(step) * QR_PER_CYCLE);
    assign in_ready = state == IDLE && !rst;

    // quarter-rounds sharing a step are all columns or all diagonals, so they never overlap
    always_comb begin
        nxt = work;
        r   = '0;
        for (int j = 0; j < 8; j++) begin
            if (j >= int'(pos) && j < int'(pos) + QR_PER_CYCLE) begin
                r = qr(work[idx(j, 0)], work[idx(j, 1)], work[idx(j, 2)], work[idx(j, 3)]);
                {nxt[idx(j, 0)], nxt[idx(j, 1)], nxt[idx(j, 2)], nxt[idx(j, 3)]} = r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            work      <= '0;
            saved     <= '0;
            block_out <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work  <= init;
                    saved <= init;
                    step  <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    work  <= nxt;
                    step  <= step == LAST ? '0 : step + 7'd1;
                    state <= step == LAST ? FINAL : ROUND;
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++) block_out[32*i +: 32] <= work[i] + saved[i];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha_core.sv
// tb_chacha_core: scoreboard bench for chacha_core against RFC 8439 and a reference ChaCha20 model.
module tb_chacha_core;
    localparam logic [255:0] RFC_KEY   = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [95:0]  RFC_NONCE = 96'h00000000_4a000000_09000000;
    localparam logic [511:0] RFC_BLOCK = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
    localparam int QI [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                                 '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [255:0] key = '0;
    logic [31:0]  counter = '0;
    logic [95:0]  nonce = '0;
    logic [2:0]   rdy, ov;
    logic [511:0] blk [3];

    int compared = 0;
    int mismatched = 0;
    logic [511:0] exp_q [$];

    always #5 clk = ~clk;

    // instance g runs 1 << g quarter-rounds per cycle; all share the same stimulus
    for (genvar g = 0; g < 3; g++) begin : g_dut
        chacha_core #(.ROUNDS(20), .QR_PER_CYCLE(1 << g)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[g]),
            .key(key), .counter(counter), .nonce(nonce),
            .out_valid(ov[g]), .out_ready(out_ready), .block_out(blk[g]));
    end

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] model(input logic [31:0] ctr);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] res;
        logic [255:0] k;
        logic [95:0]  nn;
        int a, b, c, d;
        k = RFC_KEY;
        nn = RFC_NONCE;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = nn[32*i +: 32];
        x = s;
        for (int rr = 0; rr < 10; rr++) begin
            for (int q = 0; q < 8; q++) begin
                a = QI[q][0]; b = QI[q][1]; c = QI[q][2]; d = QI[q][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [31:0] ctr, input bit push, output int waited);
        waited = 0;
        while (!rdy[0] && waited < 300) begin
            tick();
            waited++;
        end
        check("send_ready", rdy[0], 1'b1);
        key = RFC_KEY;
        counter = ctr;
        nonce = RFC_NONCE;
        in_valid = 1'b1;
        if (push) exp_q.push_back(ctr == 32'd1 ? RFC_BLOCK : model(ctr));
        tick();
        in_valid = 1'b0;
        key = ~key;
        counter = ~counter;
        nonce = ~nonce;
    endtask

    task automatic receive(input string tag, output int lat, output logic [511:0] got);
        lat = 0;
        while (!ov[0] && lat < 300) begin
            tick();
            lat++;
        end
        got = blk[0];
        check({tag, "_valid"}, ov[0], 1'b1);
        check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check(tag, blk[0], exp_q.pop_front());
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, n, seen;
        int l [3];
        logic [511:0] got, m;

        repeat (3) tick();
        check("rst_in_ready", rdy[0], 1'b0);
        check("rst_out_valid", ov[0], 1'b0);
        check("rst_block", blk[0], '0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", rdy[0], 1'b1);
        check("model_vs_rfc", model(32'd1), RFC_BLOCK);

        // RFC vector on all three widths; latency from the accepting edge
        send(32'd1, 1'b1, w);
        l = '{0, 0, 0};
        n = 0;
        while (l[0] == 0 && n < 300) begin
            tick();
            n++;
            for (int g = 0; g < 3; g++) if (ov[g] && l[g] == 0) l[g] = n;
        end
        check("lat_qr1", l[0], 81);
        check("lat_qr2", l[1], 41);
        check("lat_qr4", l[2], 21);
        check("rfc_qr2", blk[1], RFC_BLOCK);
        check("rfc_qr4", blk[2], RFC_BLOCK);
        check("rfc_qr1_sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("rfc_qr1", blk[0], exp_q.pop_front());

        // backpressure with a stray request that must be ignored
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                counter = 32'd5;
            end
            tick();
            check("bp_valid", ov[0], 1'b1);
            check("bp_block", blk[0], RFC_BLOCK);
            check("bp_in_ready", rdy[0], 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_ready", rdy[0], 1'b1);
        check("release_valid", ov[0], 1'b0);
        repeat (3) tick();
        check("stray_ignored", rdy[0], 1'b1);

        // reset during step 30
        send(32'd1, 1'b0, w);
        repeat (30) tick();
        rst = 1'b1;
        #1;
        check("midrst_ready", rdy[0], 1'b0);
        check("midrst_valid", ov[0], 1'b0);
        check("midrst_block", blk[0], '0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_release_ready", rdy[0], 1'b1);
        seen = 0;
        repeat (100) begin
            tick();
            if (ov[0]) seen++;
        end
        check("aborted_no_output", seen, 0);
        send(32'd1, 1'b1, w);
        receive("rfc_after_rst", lat, got);
        check("lat_after_rst", lat, 81);

        // back-to-back counters 1 and 2
        send(32'd1, 1'b1, w);
        receive("b2b_first", lat, got);
        send(32'd2, 1'b1, w);
        check("b2b_accept_wait", w, 0);
        receive("b2b_second", lat, got);
        m = model(32'd2);
        check("b2b_word12", got[384 +: 32], m[384 +: 32]);

        // counter wrap: no carry into the nonce words
        send(32'hffffffff, 1'b1, w);
        receive("wrap", lat, got);
        check("wrap_lat", lat, 81);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/chacha_core.md
CHACHA_CORE -- requirements
Module: chacha_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 20, total ChaCha rounds; legal values 8, 12, 20, with anything else an elaboration error.
REQ-002 SHALL have parameter QR_PER_CYCLE, default 1, quarter-rounds evaluated per clock; legal values 1, 2, 4, with anything else an elaboration error.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  core can accept a request.
REQ-007 SHALL have port key  input  256  key words 0..7 at key[32*i +: 32], already little-endian word-assembled.
REQ-008 SHALL have port counter  input  32  block counter, state word 12.
REQ-009 SHALL have port nonce  input  96  nonce words 0..2 at nonce[32*i +: 32], state words 13..15.
REQ-010 SHALL have port out_valid  output  1  keystream block valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts block.
REQ-012 SHALL have port block_out  output  512  state word i at block_out[32*i +: 32].

Function
REQ-013 SHALL build the initial state as follows: words 0..3 = 61707865, 3320646e, 79622d32, 6b206574; words 4..11 = key; word 12 = counter; words 13..15 = nonce.
REQ-014 SHALL use states IDLE, ROUND, FINAL, DONE.
REQ-015 SHALL assert in_ready only in IDLE.
REQ-016 SHALL accept a request on a clk edge with in_valid && in_ready, latch the initial state into both the working and the saved-input registers, and go to ROUND.
REQ-017 SHALL, in ROUND, apply QR_PER_CYCLE quarter-rounds per cycle (add/xor/rotate 16, 12, 8, 7, all mod 2^32) in order: column QRs (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15), then diagonal QRs (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14), repeating for ROUNDS/2 double rounds.
REQ-018 SHALL track progress with a step counter of ROUNDS*4/QR_PER_CYCLE steps; after the last step it SHALL go to FINAL.
REQ-019 SHALL, in FINAL, add the saved input words to the working words (mod 2^32, no inter-word carry), register the result onto block_out, and go to DONE.
REQ-020 SHALL assert out_valid exactly in DONE, with block_out held stable while out_valid=1 && out_ready=0.
REQ-021 SHALL go from DONE to IDLE on a clk edge with out_ready=1; in_ready SHALL rise in the following cycle.
REQ-022 SHALL give a latency of exactly ROUNDS*4/QR_PER_CYCLE + 1 cycles from the accepting edge to the first cycle of out_valid=1 (81 cycles for ROUNDS=20, QR_PER_CYCLE=1).
REQ-023 SHALL ignore in_valid and all data inputs while not in IDLE; input changes after acceptance SHALL not affect the block.
REQ-024 SHALL use counter exactly as given; it SHALL NOT increment internally, and counter=ffffffff SHALL be processed with no carry into the nonce.
REQ-025 SHALL produce results independent of QR_PER_CYCLE; only latency changes.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-ROUND or in DONE, immediately force state IDLE, step counter 0, out_valid=0, in_ready=0 while rst is held, block_out=0, and working and saved registers 0.
REQ-027 SHALL assert in_ready=1 in the first cycle after rst deasserts, with no output ever produced for a request aborted by reset.

Verification
REQ-028 SHALL cover the RFC 8439 block vector: ROUNDS=20; key words 03020100, 07060504, ..., 1f1e1d1c; counter 00000001; nonce 09000000, 4a000000, 00000000 -> block_out words 0..15 = e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2.
REQ-029 SHALL cover latency and parallelism: the REQ-028 vector with QR_PER_CYCLE = 1, 2, 4 -> identical block_out, out_valid first seen 81 / 41 / 21 cycles after the accepting edge.
REQ-030 SHALL cover backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, block_out unchanged, in_ready=0, and a new in_valid is ignored; release out_ready -> in_ready=1 on the next cycle.
REQ-031 SHALL cover reset mid-operation: pulse rst during step 30 -> out_valid never asserts for that request; a new REQ-028 request after reset yields the correct block.
REQ-032 SHALL cover back-to-back requests: counter 1 and then counter 2, each accepted on the cycle in_ready rises -> two correct blocks in order; the second block's word 12 matches a software model with counter 2.
REQ-033 SHALL cover counter wrap: counter ffffffff with the REQ-028 key and nonce -> block_out matches the software model and state words 13..15 remain the nonce.
